quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter DEB_MAX, default 50000, meaning debounce stability time in clk50m cycles (1 ms at 50 MHz), legal range 2..65535.
REQ-002 SHALL have parameter QUAD_PER_STEP, default 4, meaning valid quadrature transitions per output step, legal values 1, 2, 4.
REQ-003 SHALL have port clk50m  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port enc_a  input  1  encoder channel A, asynchronous to clk50m.
REQ-006 SHALL have port enc_b  input  1  encoder channel B, asynchronous to clk50m.
REQ-007 SHALL have port en  output  1  one-cycle step strobe, drives up/down counter enable.
REQ-008 SHALL have port down  output  1  step direction, 1 = decrement, valid only with en.
REQ-009 SHALL have port err  output  1  one-cycle strobe on illegal quadrature transition.

Function
REQ-010 SHALL pass each of enc_a, enc_b through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized channel independently: stable value updates only after synced value differs from it for DEB_MAX consecutive cycles; any return to equality clears the debounce counter.
REQ-012 SHALL implement FSM states ST_INIT and ST_RUN; ST_INIT lasts exactly 3 cycles after reset release, then loads both stable values and prev code from synchronized inputs, sub-count = 0, and enters ST_RUN, with no en/err during ST_INIT.
REQ-013 SHALL form code = {stable_a, stable_b} and compare it each cycle in ST_RUN to registered prev code.
REQ-014 SHALL treat 00->10->11->01->00 as clockwise (+1 to sub-count) and the reverse sequence as counter-clockwise (-1).
REQ-015 SHALL, when both code bits change in the same cycle, pulse err for 1 cycle, clear sub-count, produce no en.
REQ-016 SHALL, when sub-count reaches +QUAD_PER_STEP, assert en=1, down=0 for 1 cycle and clear sub-count; at -QUAD_PER_STEP assert en=1, down=1 and clear sub-count.
REQ-017 SHALL let a direction reversal before a full step move sub-count back toward 0 without output.
REQ-018 SHALL drive en, down, err registered; down = 0 whenever en = 0; en and err never high in the same cycle.
REQ-019 SHALL have latency: en asserted 1 cycle after the stable-code change that completes a step; pin-to-en = 2 + DEB_MAX + 1 cycles nominal (sync uncertainty +1).
REQ-020 SHALL size sub-count as signed 4-bit and debounce counter as 16-bit; no wrap possible by REQ-016.

Reset
REQ-021 SHALL, while rst = 1 at a clk50m edge, clear synchronizers, debounce counters, stable values, prev code, sub-count, en, down, err to 0 and enter ST_INIT.
REQ-022 SHALL abandon any partial step or debounce in progress on reset mid-operation; no en/err pulse generated by the reset itself.

Structure
REQ-023 SHALL place in shared package quad_pkg: enum state_t {ST_INIT, ST_RUN}, typedef quad_code_t (logic [1:0]), constants CODE_00/10/11/01, DEB_CNT_W = 16.
REQ-024 SHALL instantiate sub-module debounce (sync + debounce, parameter DEB_MAX) once per channel; FSM and step logic stay in quad_decoder.

Verification (DEB_MAX = 4, QUAD_PER_STEP = 4 unless stated)
REQ-025 SHALL test: inputs idle at 11 through reset -> no en/err after reset release; prev code = 11.
REQ-026 SHALL test: one clean CW cycle 00->10->11->01->00, each level held 10 cycles -> exactly one en=1/down=0 pulse, 1 cycle after final stable change.
REQ-027 SHALL test: one CCW cycle -> exactly one en=1/down=1; with QUAD_PER_STEP = 1 same stimulus -> 4 down pulses.
REQ-028 SHALL test: enc_a glitch 3 cycles wide -> no stable change, no en; glitch 6 cycles -> stable change.
REQ-029 SHALL test: enc_a and enc_b toggled same cycle from 00 to 11 -> err pulse 1 cycle, no en, sub-count 0.
REQ-030 SHALL test: 3 CW transitions, 1 CCW, rst asserted mid-transition -> no en at any point, outputs 0, ST_INIT re-entered.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
package quad_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef logic [1:0] quad_code_t;

  localparam quad_code_t CODE_00 = 2'b00;
  localparam quad_code_t CODE_10 = 2'b10;
  localparam quad_code_t CODE_11 = 2'b11;
  localparam quad_code_t CODE_01 = 2'b01;

  localparam int DEB_CNT_W = 16;

  // Position of a code along the clockwise cycle 00->10->11->01.
  // The 2-bit difference of two phases encodes the move: 1 = CW, 3 = CCW, 2 = illegal.
  function automatic logic [1:0] code_phase(input quad_code_t c);
    logic [1:0] ph;
    ph = 2'd0;
    case (c)
      CODE_00: ph = 2'd0;
      CODE_10: ph = 2'd1;
      CODE_11: ph = 2'd2;
      CODE_01: ph = 2'd3;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/quad_decoder_debounce.sv
// Per-channel 2-flop synchronizer followed by a stability debouncer.
module debounce
  import quad_pkg::*;
#(
  parameter int DEB_MAX = 50000
) (
  input  logic clk50m,
  input  logic rst,
  input  logic din,
  input  logic load,
  output logic synced,
  output logic stable
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_MAX - 1);

  logic                 meta;
  logic [DEB_CNT_W-1:0] cnt;

  // Synchronize the pin, then move stable only after DEB_MAX consecutive differing samples.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta   <= din;
      synced <= meta;
      if (load) begin
        stable <= synced;
        cnt    <= '0;
      end else if (synced != stable) begin
        if (cnt == DEB_LAST) begin
          stable <= synced;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounced A/B channels to step enable, direction and error strobes.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEB_MAX       = 50000,
  parameter int QUAD_PER_STEP = 4
) (
  input  logic clk50m,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  output logic en,
  output logic down,
  output logic err
);

  localparam logic signed [3:0] STEP_POS = 4'(QUAD_PER_STEP);
  localparam logic signed [3:0] STEP_NEG = -STEP_POS;

  state_t            state, state_nxt;
  logic [1:0]        init_cnt;
  logic              load;
  logic              synced_a, synced_b;
  logic              stable_a, stable_b;
  quad_code_t        code, prev_code;
  logic [1:0]        move;
  logic signed [3:0] sub_cnt;
  logic signed [3:0] sub_inc, sub_dec;

  debounce #(.DEB_MAX(DEB_MAX)) u_deb_a (
    .clk50m (clk50m),
    .rst    (rst),
    .din    (enc_a),
    .load   (load),
    .synced (synced_a),
    .stable (stable_a)
  );

  debounce #(.DEB_MAX(DEB_MAX)) u_deb_b (
    .clk50m (clk50m),
    .rst    (rst),
    .din    (enc_b),
    .load   (load),
    .synced (synced_b),
    .stable (stable_b)
  );

  // Hold ST_INIT for three cycles so the synchronizers are filled before loading.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == 2'd2) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Classify the code change and form the candidate sub-counts.
  always_comb begin
    code    = {stable_a, stable_b};
    move    = code_phase(code) - code_phase(prev_code);
    sub_inc = sub_cnt + 4'sd1;
    sub_dec = sub_cnt - 4'sd1;
  end

  // State register, init timer, sub-count accumulation and registered strobes.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= 2'd0;
      prev_code <= CODE_00;
      sub_cnt   <= 4'sd0;
      en        <= 1'b0;
      down      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      en    <= 1'b0;
      down  <= 1'b0;
      err   <= 1'b0;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 2'd1;
        if (load) begin
          prev_code <= {synced_a, synced_b};
          sub_cnt   <= 4'sd0;
        end
      end else begin
        prev_code <= code;
        case (move)
          2'd1: begin
            if (sub_inc == STEP_POS) begin
              en      <= 1'b1;
              sub_cnt <= 4'sd0;
            end else begin
              sub_cnt <= sub_inc;
            end
          end
          2'd3: begin
            if (sub_dec == STEP_NEG) begin
              en      <= 1'b1;
              down    <= 1'b1;
              sub_cnt <= 4'sd0;
            end else begin
              sub_cnt <= sub_dec;
            end
          end
          2'd2: begin
            err     <= 1'b1;
            sub_cnt <= 4'sd0;
          end
          default: sub_cnt <= sub_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: directed scenarios plus a random walk against a reference model.
module tb_quad_decoder;
  import quad_pkg::*;

  localparam int DEB = 4;
  localparam logic [15:0] WMASK = 16'((1 << DEB) - 1);

  logic clk50m = 1'b0;
  logic rst    = 1'b1;
  logic enc_a  = 1'b1;
  logic enc_b  = 1'b1;
  logic en4, down4, err4, en1, down1, err1;

  int total = 0;
  int bad   = 0;

  always #5 clk50m = ~clk50m;

  quad_decoder #(.DEB_MAX(DEB), .QUAD_PER_STEP(4)) dut4 (
    .clk50m (clk50m), .rst (rst), .enc_a (enc_a), .enc_b (enc_b),
    .en (en4), .down (down4), .err (err4)
  );

  quad_decoder #(.DEB_MAX(DEB), .QUAD_PER_STEP(1)) dut1 (
    .clk50m (clk50m), .rst (rst), .enc_a (enc_a), .enc_b (enc_b),
    .en (en1), .down (down1), .err (err1)
  );

  // Reference model state: index 0 = channel A, 1 = channel B; per-DUT index 0 = Q4, 1 = Q1.
  int          QS[2]      = '{4, 1};
  int          POS[4]     = '{0, 3, 1, 2};
  logic [1:0]  CODE_AT[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  bit          ms0[2], ms1[2], mst[2];
  logic [15:0] win[2];
  logic [1:0]  mprev;
  int          msub[2];
  bit          mrun;
  int          minit;
  bit          xen[2], xdn[2], xer[2];

  int  en4_n, dn4_n, err4_n, en1_n, dn1_n, err1_n;
  bit  sa_hi;
  logic [1:0] cur;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit pa, input bit pb);
    bit pin[2];
    int mov;
    logic [1:0] code;
    pin[0] = pa;
    pin[1] = pb;
    for (int d = 0; d < 2; d++) begin
      xen[d] = 0; xdn[d] = 0; xer[d] = 0;
    end
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        ms0[c] = 0; ms1[c] = 0; mst[c] = 0; win[c] = '0; msub[c] = 0;
      end
      mprev = 2'b00;
      mrun  = 0;
      minit = 3;
    end else begin
      if (!mrun) begin
        minit--;
        if (minit == 0) begin
          for (int c = 0; c < 2; c++) begin
            mst[c] = ms1[c]; win[c] = '0; msub[c] = 0;
          end
          mprev = {ms1[0], ms1[1]};
          mrun  = 1;
        end
      end else begin
        code = {mst[0], mst[1]};
        mov  = (POS[code] - POS[mprev] + 4) % 4;
        for (int d = 0; d < 2; d++) begin
          if (mov == 2) begin
            xer[d] = 1; msub[d] = 0;
          end else if (mov != 0) begin
            msub[d] += (mov == 1) ? 1 : -1;
            if (msub[d] == QS[d]) begin
              xen[d] = 1; msub[d] = 0;
            end else if (msub[d] == -QS[d]) begin
              xen[d] = 1; xdn[d] = 1; msub[d] = 0;
            end
          end
        end
        mprev = code;
        for (int c = 0; c < 2; c++) begin
          win[c] = {win[c][14:0], ms1[c] != mst[c]};
          if ((win[c] & WMASK) == WMASK) begin
            mst[c] = ms1[c]; win[c] = '0;
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        ms1[c] = ms0[c]; ms0[c] = pin[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk50m);
    model_edge(rst, enc_a, enc_b);
    #1;
    check1("en_q4", en4, xen[0]);
    check1("down_q4", down4, xdn[0]);
    check1("err_q4", err4, xer[0]);
    check1("en_q1", en1, xen[1]);
    check1("down_q1", down1, xdn[1]);
    check1("err_q1", err1, xer[1]);
    check1("stable_a", dut4.stable_a, mst[0]);
    check1("stable_b", dut4.stable_b, mst[1]);
    if (en4 === 1'b1) en4_n++;
    if (en4 === 1'b1 && down4 === 1'b1) dn4_n++;
    if (err4 === 1'b1) err4_n++;
    if (en1 === 1'b1) en1_n++;
    if (en1 === 1'b1 && down1 === 1'b1) dn1_n++;
    if (err1 === 1'b1) err1_n++;
    if (dut4.stable_a === 1'b1) sa_hi = 1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_code(input logic [1:0] c);
    enc_a = c[1];
    enc_b = c[0];
    cur   = c;
  endtask

  task automatic clear_counts();
    en4_n = 0; dn4_n = 0; err4_n = 0; en1_n = 0; dn1_n = 0; err1_n = 0; sa_hi = 0;
  endtask

  initial begin
    int r;
    // Idle at 11 through reset.
    set_code(2'b11);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    clear_counts();
    hold(12);
    check32("idle_en", en4_n, 0);
    check32("idle_err", err4_n, 0);
    check32("idle_prev", 32'(dut4.prev_code), 32'(CODE_11));
    check32("idle_state", 32'(dut4.state), 32'(ST_RUN));

    // Re-reset at 00 to start the rotation tests from the cycle origin.
    set_code(2'b00);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(12);

    // One clean clockwise cycle.
    clear_counts();
    set_code(2'b10); hold(10);
    set_code(2'b11); hold(10);
    set_code(2'b01); hold(10);
    set_code(2'b00); hold(10);
    check32("cw_en_q4", en4_n, 1);
    check32("cw_down_q4", dn4_n, 0);
    check32("cw_en_q1", en1_n, 4);
    check32("cw_down_q1", dn1_n, 0);

    // One counter-clockwise cycle.
    clear_counts();
    set_code(2'b01); hold(10);
    set_code(2'b11); hold(10);
    set_code(2'b10); hold(10);
    set_code(2'b00); hold(10);
    check32("ccw_en_q4", en4_n, 1);
    check32("ccw_down_q4", dn4_n, 1);
    check32("ccw_en_q1", en1_n, 4);
    check32("ccw_down_q1", dn1_n, 4);

    // Short glitch on A is filtered; a longer one gets through.
    clear_counts();
    enc_a = 1'b1; hold(3);
    enc_a = 1'b0; hold(12);
    check32("glitch3_stable", 32'(sa_hi), 0);
    check32("glitch3_en", en4_n + en1_n, 0);
    enc_a = 1'b1; hold(6);
    enc_a = 1'b0; hold(12);
    check32("glitch6_stable", 32'(sa_hi), 1);
    check32("glitch6_en_q4", en4_n, 0);

    // Both channels toggled together.
    clear_counts();
    set_code(2'b11); hold(12);
    check32("both_err_q4", err4_n, 1);
    check32("both_en_q4", en4_n, 0);
    check32("both_err_q1", err1_n, 1);
    check32("both_sub", 32'(dut4.sub_cnt), 0);

    // Partial motion, then reset in the middle of a transition.
    clear_counts();
    set_code(2'b01); hold(10);
    set_code(2'b00); hold(10);
    set_code(2'b10); hold(10);
    set_code(2'b00); hold(10);
    set_code(2'b10); hold(3);
    rst = 1'b1;
    hold(2);
    check1("rst_en", en4, 1'b0);
    check1("rst_down", down4, 1'b0);
    check1("rst_err", err4, 1'b0);
    check32("rst_state", 32'(dut4.state), 32'(ST_INIT));
    rst = 1'b0;
    hold(20);
    check32("rst_seq_en_q4", en4_n, 0);
    check32("rst_seq_err_q4", err4_n, 0);

    // Random walk with random hold times, checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) set_code(cur ^ 2'b11);
      else if (r < 6) set_code(CODE_AT[(POS[cur] + 1) % 4]);
      else set_code(CODE_AT[(POS[cur] + 3) % 4]);
      hold(int'($urandom_range(1, 12)));
    end
    hold(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
